// File: rtl/pr_collector_if.sv
// Record stream from pr_collector to its consumer: valid/ready handshake
// carrying {mismatch, compare, result}.
interface pr_collector_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 out_valid;
  logic                 out_ready;
  logic [3*WIDTH+2:0]   out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/pr_collector.sv
// Captures pipeline sum/product results via a launch-matched tag delay line into a
// FWFT record FIFO. Golden self-check is built only when PR_COLLECTOR_SELFCHECK_EN is defined.
module pr_collector #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LATENCY = 3,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 launch,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  input  logic [WIDTH-1:0]     d,
  input  logic [WIDTH+1:0]     result,
  input  logic [2*WIDTH-1:0]   compare,
  pr_collector_if.master       out,
  output logic [15:0]          launch_cnt,
  output logic [7:0]           drop_cnt,
  output logic [7:0]           err_cnt,
  output logic                 overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned RW = 3*WIDTH + 3;

  logic [LATENCY-1:0] tag_v;
  logic               cap;
  logic               mismatch;
  logic [RW-1:0]      record;

  logic [RW-1:0]      mem [DEPTH];
  logic [AW:0]        wptr;
  logic [AW:0]        rptr;
  logic               full;
  logic               empty;
  logic               pop;
  logic               push;
  logic               drop;

  // Shift a launch marker through LATENCY stages; the cast keeps LATENCY=1 legal.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tag_v <= '0;
    end else begin
      tag_v <= LATENCY'({tag_v, launch});
    end
  end

  assign cap = tag_v[LATENCY-1];

`ifdef PR_COLLECTOR_SELFCHECK_EN
  logic [WIDTH+1:0]   exp_sum  [LATENCY];
  logic [2*WIDTH-1:0] exp_prod [LATENCY];
  logic [WIDTH+1:0]   gold_sum;
  logic [2*WIDTH-1:0] gold_prod;

  assign gold_sum  = (WIDTH+2)'(a) + (WIDTH+2)'(b) + (WIDTH+2)'(c) + (WIDTH+2)'(d);
  assign gold_prod = (2*WIDTH)'(a) * (2*WIDTH)'(b);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < LATENCY; k++) begin
        exp_sum[k]  <= '0;
        exp_prod[k] <= '0;
      end
    end else begin
      exp_sum[0]  <= gold_sum;
      exp_prod[0] <= gold_prod;
      for (int unsigned k = 1; k < LATENCY; k++) begin
        exp_sum[k]  <= exp_sum[k-1];
        exp_prod[k] <= exp_prod[k-1];
      end
    end
  end

  assign mismatch = (result != exp_sum[LATENCY-1]) | (compare != exp_prod[LATENCY-1]);

  // Counts every mismatching capture, including records that end up dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (cap && mismatch && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  logic unused_ops;

  assign unused_ops = ^{a, b, c, d};
  assign mismatch   = 1'b0;
  assign err_cnt    = '0;
`endif

  assign record = {mismatch, compare, result};

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = !empty && out.out_ready;
  // When full, a same-cycle pop frees the slot being written, so the push still lands.
  assign push  = cap && (!full || pop);
  assign drop  = cap && full && !pop;

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wptr[AW-1:0]] <= record;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  assign out.out_valid = !empty;
  assign out.out_data  = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      launch_cnt <= '0;
      drop_cnt   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (launch) launch_cnt <= launch_cnt + 16'd1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_pr_collector.sv
// Self-checking bench for pr_collector: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_pr_collector;

  localparam int W     = 8;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;

`ifdef PR_COLLECTOR_SELFCHECK_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            launch = 1'b0;
  logic [W-1:0]    a = '0, b = '0, c = '0, d = '0;
  logic [W+1:0]    result = '0;
  logic [2*W-1:0]  compare = '0;
  logic [15:0]     launch_cnt;
  logic [7:0]      drop_cnt, err_cnt;
  logic            overflow;

  pr_collector_if #(.WIDTH(W)) bus ();

  pr_collector #(.WIDTH(W), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .launch     (launch),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .result     (result),
    .compare    (compare),
    .out        (bus.master),
    .launch_cnt (launch_cnt),
    .drop_cnt   (drop_cnt),
    .err_cnt    (err_cnt),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned     due;
    logic [W+1:0]    sum;
    logic [2*W-1:0]  prod;
    bit              bad;
  } pend_t;

  typedef struct {
    logic [W-1:0]    va, vb, vc, vd;
    bit              bad;
    logic [W+1:0]    er;
    logic [2*W-1:0]  ec;
    bit              em;
  } vec_t;

  pend_t           pend [$];
  logic [3*W+2:0]  mq [$];
  int unsigned     cyc = 0;
  int              m_lc = 0, m_dc = 0, m_ec = 0;
  bit              m_ovf = 1'b0;
  int              checks = 0, errors = 0;
  vec_t            vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_model();
    chk("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
    chk("out_data", 64'(bus.out_data), (mq.size() != 0) ? 64'(mq[0]) : 64'd0);
    chk("launch_cnt", 64'(launch_cnt), 64'(m_lc % 65536));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_dc));
    chk("err_cnt", 64'(err_cnt), 64'(m_ec));
    chk("overflow", 64'(overflow), 64'(m_ovf));
  endtask

  // One clock: drive inputs, feed the due result, advance the reference model, compare.
  task automatic step(input bit l, input logic [W-1:0] ia, ib, ic, id,
                      input bit bad, input bit rdy);
    bit             cap;
    bit             pop;
    bit             mis;
    pend_t          it;
    logic [3*W+2:0] rec;
    cap = (pend.size() != 0) && (pend[0].due == cyc);
    launch = l; a = ia; b = ib; c = ic; d = id;
    bus.out_ready = rdy;
    if (cap) begin
      it = pend.pop_front();
      result  = it.sum + (it.bad ? 10'd1 : 10'd0);
      compare = it.prod;
      mis = SC && it.bad;
    end else begin
      result  = (W+2)'($urandom);
      compare = (2*W)'($urandom);
      mis = 1'b0;
    end
    if (l) begin
      it.due  = cyc + LAT;
      it.sum  = (W+2)'(ia) + (W+2)'(ib) + (W+2)'(ic) + (W+2)'(id);
      it.prod = (2*W)'(ia) * (2*W)'(ib);
      it.bad  = bad;
      pend.push_back(it);
    end
    @(posedge clock);
    pop = (mq.size() != 0) && rdy;
    if (l) m_lc++;
    if (pop) void'(mq.pop_front());
    if (cap) begin
      rec = {mis, compare, result};
      if (mis && m_ec < 255) m_ec++;
      if (mq.size() < DEPTH) mq.push_back(rec);
      else begin
        if (m_dc < 255) m_dc++;
        m_ovf = 1'b1;
      end
    end
    cyc++;
    #1;
    check_model();
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, '0, '0, '0, '0, 1'b0, rdy);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    launch = 1'b0;
    pend.delete();
    mq.delete();
    m_lc = 0; m_dc = 0; m_ec = 0; m_ovf = 1'b0;
    #1;
    chk("rst_async_valid", 64'(bus.out_valid), 64'd0);
    repeat (2) @(posedge clock);
    cyc += 2;
    #1;
    check_model();
    reset = 1'b0;
  endtask

  initial begin
    int unsigned pops;
    bus.out_ready = 1'b0;

    vecs[0] = '{8'd3,   8'd4,   8'd5,   8'd6,   1'b0, 10'd18,   16'd12,    1'b0};
    vecs[1] = '{8'd3,   8'd4,   8'd5,   8'd6,   1'b1, 10'd19,   16'd12,    SC};
    vecs[2] = '{8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 10'd1020, 16'd65025, 1'b0};
    vecs[3] = '{8'd0,   8'd0,   8'd0,   8'd0,   1'b0, 10'd0,    16'd0,     1'b0};
    vecs[4] = '{8'd200, 8'd100, 8'd7,   8'd9,   1'b0, 10'd316,  16'd20000, 1'b0};

    repeat (2) @(posedge clock);
    do_reset();
    chk("reset_data", 64'(bus.out_data), 64'd0);
    chk("reset_launch_cnt", 64'(launch_cnt), 64'd0);

    // Directed vectors: record appears exactly LAT+1 cycles after launch.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].vd, vecs[i].bad, 1'b1);
      for (int k = 1; k < LAT; k++) idle(1'b0);
      chk("latency_early", 64'(bus.out_valid), 64'd0);
      idle(1'b0);
      chk("latency_valid", 64'(bus.out_valid), 64'd1);
      chk("vec_result", 64'(bus.out_data[W+1:0]), 64'(vecs[i].er));
      chk("vec_compare", 64'(bus.out_data[3*W+1:W+2]), 64'(vecs[i].ec));
      chk("vec_mismatch", 64'(bus.out_data[3*W+2]), 64'(vecs[i].em));
      if (i == 0) chk("first_launch_cnt", 64'(launch_cnt), 64'd1);
      if (i == 1) chk("bad_err_cnt", 64'(err_cnt), SC ? 64'd1 : 64'd0);
      idle(1'b1);
    end

    // Overflow: 6 launches into a 4-deep FIFO with no consumer.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, W'(i + 1), '0, '0, '0, 1'b0, 1'b0);
    repeat (LAT + 2) idle(1'b0);
    chk("ovf_drop_cnt", 64'(drop_cnt), 64'd2);
    chk("ovf_overflow", 64'(overflow), 64'd1);
    pops = 0;
    for (int i = 0; i < 10 && bus.out_valid; i++) begin
      chk("drain_order", 64'(bus.out_data[W+1:0]), 64'(i + 1));
      idle(1'b1);
      pops++;
    end
    chk("drain_count", 64'(pops), 64'd4);

    // Full FIFO with push and pop on the same edge: no drop, still 4 held.
    for (int i = 0; i < DEPTH; i++) step(1'b1, W'(i + 10), '0, '0, '0, 1'b0, 1'b0);
    step(1'b1, 8'd50, '0, '0, '0, 1'b0, 1'b0);
    for (int k = 1; k < LAT; k++) idle(1'b0);
    chk("full_before", 64'(dut.full), 64'd1);
    idle(1'b1);
    idle(1'b0);
    chk("pushpop_no_drop", 64'(drop_cnt), 64'd2);
    pops = 0;
    for (int i = 0; i < 10 && bus.out_valid; i++) begin
      idle(1'b1);
      pops++;
    end
    chk("pushpop_occupancy", 64'(pops), 64'd4);

    // Reset one cycle after the second launch discards everything in flight.
    step(1'b1, 8'd1, 8'd2, 8'd3, 8'd4, 1'b0, 1'b1);
    step(1'b1, 8'd5, 8'd6, 8'd7, 8'd8, 1'b0, 1'b1);
    idle(1'b1);
    do_reset();
    repeat (LAT + 3) idle(1'b1);
    chk("post_reset_valid", 64'(bus.out_valid), 64'd0);
    chk("post_reset_launch_cnt", 64'(launch_cnt), 64'd0);
    chk("post_reset_drop_cnt", 64'(drop_cnt), 64'd0);

    // Randomized traffic with occasional faulty results and back-pressure.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, W'($urandom), W'($urandom), W'($urandom), W'($urandom),
           ($urandom % 8) == 0, ($urandom % 3) != 0);
    end
    repeat (LAT + DEPTH + 2) idle(1'b1);
    chk("final_empty", 64'(bus.out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
